data_mem_responder: RTL and testbench

//  Data-memory responder on the far side of the CPU datapath load/store port.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/sp_ram_32.sv | 26 ++
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, word
// geometry, wait-counter width and the address legality check.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

  // A byte offset is illegal when it is not word aligned or lies past the end
  // of the array. An address below the base wraps to a huge offset and fails
  // the range test.
  function automatic logic addr_err(input logic [31:0] offset, input logic [31:0] limit);
    return (offset[1:0] != 2'b00) || (offset >= limit);
  endfunction

endpackage

// File: rtl/sp_ram_32.sv
// DEPTH x 32 synchronous single-port RAM. Write and registered read happen
// on the same clock edge; the read register keeps its value when not enabled.
module sp_ram_32 #(
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Array write and registered read share one edge.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: captures one word request, waits WAIT_CYCLES,
// performs a single RAM access and answers with a one-cycle ready pulse.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(WORD_BYTES * DEPTH);

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_we, w_we_next;
  logic [31:0]        r_addr, w_addr_next;
  logic [31:0]        r_wdata, w_wdata_next;
  logic               r_err, w_err_next;
  logic               r_rdata_zero, w_rdata_zero_next;

  logic               w_access;
  logic               w_acc_we;
  logic [31:0]        w_acc_addr;
  logic [31:0]        w_acc_wdata;
  logic [31:0]        w_offset;
  logic               w_bad;
  logic               w_ram_we;
  logic               w_ram_re;
  logic [31:0]        w_ram_q;

  // In IDLE the access (if zero-wait) uses the live inputs; later the latched copy.
  assign w_acc_addr  = (r_state == ST_IDLE) ? addr  : r_addr;
  assign w_acc_we    = (r_state == ST_IDLE) ? we    : r_we;
  assign w_acc_wdata = (r_state == ST_IDLE) ? wdata : r_wdata;
  assign w_offset    = w_acc_addr - BASE_ADDR;
  assign w_bad       = addr_err(w_offset, LIMIT);

  // Next-state, wait counter, request latch and response flags.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_we_next         = r_we;
    w_addr_next       = r_addr;
    w_wdata_next      = r_wdata;
    w_err_next        = r_err;
    w_rdata_zero_next = r_rdata_zero;
    w_access          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_we_next    = we;
          w_addr_next  = addr;
          w_wdata_next = wdata;
          if (w_bad) begin
            w_state_next      = ST_RESP;
            w_err_next        = 1'b1;
            w_rdata_zero_next = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            w_access     = 1'b1;
            w_state_next = ST_RESP;
          end else begin
            w_state_next = ST_BUSY;
            w_cnt_next   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      ST_BUSY: begin
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_access     = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_access) begin
      w_err_next = 1'b0;
      if (!w_acc_we) w_rdata_zero_next = 1'b0;
    end
  end

  // A reset edge suppresses the RAM access so an aborted store never lands.
  assign w_ram_we = w_access &  w_acc_we & rst;
  assign w_ram_re = w_access & ~w_acc_we & rst;

  // State and latch registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_rdata_zero <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_we         <= w_we_next;
      r_addr       <= w_addr_next;
      r_wdata      <= w_wdata_next;
      r_err        <= w_err_next;
      r_rdata_zero <= w_rdata_zero_next;
    end
  end

  sp_ram_32 #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_offset[AW+1:2]),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_ram_q)
  );

  // The RAM read register cannot be reset, so a flag forces rdata to zero
  // after reset or an error response until the next successful load.
  assign rdata = r_rdata_zero ? 32'h0 : w_ram_q;
  assign ready = (r_state == ST_RESP);
  assign busy  = (r_state != ST_IDLE);
  assign err   = ready & r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (2 wait states / base 0 / 1024 words,
// and 0 wait states / base 0x100 / 64 words) against a behavioural model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic        busy  [2];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(2), .INIT_FILE("")) u_a (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0]));

  data_mem_responder #(.DEPTH(64), .BASE_ADDR(32'h100), .WAIT_CYCLES(0), .INIT_FILE("")) u_b (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1]));

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Reference memory keyed by {instance, byte address}; only written words are loaded.
  bit [31:0]   mdl [bit [32:0]];
  bit [31:0]   exp_rd [2];
  bit [31:0]   wq0 [$];
  bit [31:0]   wq1 [$];

  function automatic int wait_of(input int s);
    return (s == 0) ? 2 : 0;
  endfunction
  function automatic bit [31:0] base_of(input int s);
    return (s == 0) ? 32'h0 : 32'h100;
  endfunction
  function automatic int depth_of(input int s);
    return (s == 0) ? 1024 : 64;
  endfunction
  function automatic bit is_err(input int s, input bit [31:0] a);
    bit [31:0] off;
    off = a - base_of(s);
    return (off[1:0] != 2'b00) || (off >= 32'(4 * depth_of(s)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One complete request/response with latency, flag, data and pulse-width checks.
  task automatic txn(input int s, input bit w, input bit [31:0] a, input bit [31:0] d);
    bit        e;
    int        lat;
    bit [32:0] key;
    e   = is_err(s, a);
    key = {s[0], a};
    @(negedge clk);
    req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
    @(posedge clk); #1;
    req[s] = 1'b0; we[s] = 1'($urandom); addr[s] = $urandom; wdata[s] = $urandom;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (ready[s] === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (e) exp_rd[s] = 32'h0;
    else if (w) begin
      mdl[key] = d;
      if (s == 0) wq0.push_back(a); else wq1.push_back(a);
    end else exp_rd[s] = mdl[key];
    chk($sformatf("latency s%0d a=%h", s, a), 32'(lat), 32'(e ? 0 : wait_of(s)));
    chk($sformatf("err s%0d a=%h", s, a), 32'(err[s]), 32'(e));
    chk($sformatf("rdata s%0d a=%h", s, a), rdata[s], exp_rd[s]);
    chk($sformatf("busy_resp s%0d", s), 32'(busy[s]), 32'd1);
    $display("txn s=%0d we=%0b addr=%h wdata=%h lat=%0d err=%0b rdata=%h", s, w, a, d, lat, err[s], rdata[s]);
    @(posedge clk); #1;
    chk($sformatf("pulse s%0d", s), 32'(ready[s]), 32'd0);
    chk($sformatf("err_low s%0d", s), 32'(err[s]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit [31:0] hist [16];
    bit [31:0] a;
    int        r;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
    end

    // Reset held three cycles.
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_ready s%0d", s), 32'(ready[s]), 32'd0);
      chk($sformatf("rst_err s%0d", s), 32'(err[s]), 32'd0);
      chk($sformatf("rst_busy s%0d", s), 32'(busy[s]), 32'd0);
      chk($sformatf("rst_rdata s%0d", s), rdata[s], 32'h0);
      exp_rd[s] = 32'h0;
    end
    @(negedge clk); rst = 1'b1;

    // Store then load, two wait states.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h10, 32'h0);
    // Zero wait states; word 0 sits at the base address.
    txn(1, 1'b1, 32'h100, 32'h12345678);
    txn(1, 1'b0, 32'h100, 32'h0);

    // Error handling and range boundaries.
    txn(0, 1'b1, 32'h12, 32'h55555555);
    txn(0, 1'b0, 32'h10, 32'h0);
    txn(0, 1'b0, 32'h1000, 32'h0);
    txn(0, 1'b1, 32'hFFC, 32'hA5A5F00F);
    txn(0, 1'b0, 32'hFFC, 32'h0);
    txn(1, 1'b1, 32'h1FC, 32'h0BADCAFE);
    txn(1, 1'b0, 32'h1FC, 32'h0);
    txn(1, 1'b0, 32'h200, 32'h0);
    txn(1, 1'b0, 32'hFC, 32'h0);

    // Reset during BUSY aborts a store.
    txn(0, 1'b1, 32'h20, 32'h11111111);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFEF00D;
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("abort_busy_before", 32'(busy[0]), 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_after", 32'(busy[0]), 32'd0);
    chk("abort_ready", 32'(ready[0]), 32'd0);
    @(negedge clk); rst = 1'b1;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_noresp c%0d", k), 32'(ready[0]), 32'd0);
    end
    chk("abort_rdata_cleared", rdata[0], 32'h0);
    txn(0, 1'b0, 32'h20, 32'h0);

    // Continuous req with a new address every cycle: one acceptance per 4 cycles.
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      hist[c] = wq0[$urandom_range(0, wq0.size() - 1)];
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = hist[c];
      @(posedge clk); #1;
      chk($sformatf("proto_ready c%0d", c), 32'(ready[0]), 32'((c % 4) == 2));
      if ((c % 4) == 2) begin
        exp_rd[0] = mdl[{1'b0, hist[c-2]}];
        chk($sformatf("proto_rdata c%0d", c), rdata[0], exp_rd[0]);
      end
    end
    @(negedge clk); req[0] = 1'b0;
    @(posedge clk); #1;
    chk("proto_idle", 32'(busy[0]), 32'd0);

    // Randomized mix of legal, misaligned and out-of-range accesses.
    for (int n = 0; n < 30; n++) begin
      int s;
      s = n % 2;
      r = int'($urandom_range(0, 5));
      a = base_of(s) + 4 * $urandom_range(0, depth_of(s) - 1);
      case (r)
        0, 1: txn(s, 1'b1, a, $urandom);
        2: begin
          if (s == 0) a = wq0[$urandom_range(0, wq0.size() - 1)];
          else        a = wq1[$urandom_range(0, wq1.size() - 1)];
          txn(s, 1'b0, a, 32'h0);
        end
        3: txn(s, 1'($urandom), a + $urandom_range(1, 3), $urandom);
        4: txn(s, 1'($urandom), base_of(s) + 32'(4 * depth_of(s)) + 4 * $urandom_range(0, 255), $urandom);
        default: txn(s, 1'($urandom), base_of(s) - 4 * $urandom_range(1, 64), $urandom);
      endcase
    end
    // Re-read every word written so far to catch stray or missing writes.
    for (int i = 0; i < wq1.size(); i++) txn(1, 1'b0, wq1[i], 32'h0);
    for (int i = 0; i < 8; i++) txn(0, 1'b0, wq0[$urandom_range(0, wq0.size() - 1)], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
